// File: rtl/pipe_in_buffer_pkg.sv
// Shared definitions for the host pipe-in buffer: output-stage state encoding
// and the buffer depth derivation.
package pipe_in_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_VALID = 2'd2
  } out_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/pipe_buffer_ram.sv
// Simple dual-port storage with a one-cycle synchronous read; no reset so it
// maps onto block RAM. A read of an address written on the same edge returns old data.
module pipe_buffer_ram
  import pipe_in_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:depth_of(ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pipe_in_buffer.sv
// Host pipe-in buffer: accepts one word per cycle from the host interface and
// presents it to a valid/ready consumer through a registered output stage.
module pipe_in_buffer
  import pipe_in_buffer_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                    ti_clk,
  input  logic                    ti_rst_soft,
  input  logic                    ti_in_data_en,
  input  logic [DATA_WIDTH-1:0]   ti_in_data,
  output logic [15:0]             ti_in_available,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MEM_ADDR_WIDTH:0] level,
  output logic                    overflow,
  output out_state_t              dbg_state
);

  localparam int unsigned DEPTH = depth_of(MEM_ADDR_WIDTH);
  localparam logic [MEM_ADDR_WIDTH:0]   DEPTH_CNT   = (MEM_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [MEM_ADDR_WIDTH:0]   CNT_ONE     = (MEM_ADDR_WIDTH+1)'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] PTR_ONE     = MEM_ADDR_WIDTH'(1);
  localparam logic [15:0]               DEPTH_AVAIL = 16'(DEPTH);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that transfer.

  out_state_t                state;
  logic [MEM_ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [MEM_ADDR_WIDTH:0]   mem_cnt;
  logic [DATA_WIDTH-1:0]     ram_q, byp_data, rd_word;
  logic                      byp_hit;
  logic                      push, pop, mem_pop;

  assign push       = ti_in_data_en && !ti_rst_soft && (level < DEPTH_CNT);
  assign pop        = out_valid && out_ready;
  assign mem_pop    = (state == ST_LOAD) || ((state == ST_VALID) && pop && (mem_cnt != '0));
  assign rd_ptr_nxt = mem_pop ? rd_ptr + PTR_ONE : rd_ptr;
  // A word written on the same edge it was read is taken from the bypass register.
  assign rd_word    = byp_hit ? byp_data : ram_q;
  assign dbg_state  = state;

  pipe_buffer_ram #(
    .ADDR_WIDTH (MEM_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (ti_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (ti_in_data),
    .rd_en   (1'b1),
    .rd_addr (rd_ptr_nxt),
    .rd_data (ram_q)
  );

  always_ff @(posedge ti_clk) begin
    byp_data <= ti_in_data;
  end

  always_ff @(posedge ti_clk) begin
    if (ti_rst_soft) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      mem_cnt         <= '0;
      level           <= '0;
      overflow        <= 1'b0;
      ti_in_available <= DEPTH_AVAIL;
      byp_hit         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   level <= level + CNT_ONE;
        2'b01:   level <= level - CNT_ONE;
        default: level <= level;
      endcase
      case ({push, mem_pop})
        2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
        2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
        default: mem_cnt <= mem_cnt;
      endcase
      if (ti_in_data_en && !push) overflow <= 1'b1;
      ti_in_available <= DEPTH_AVAIL - 16'(level);
      byp_hit         <= push && (wr_ptr == rd_ptr_nxt);
    end
  end

  // Output stage; mem_cnt counts words still in memory, excluding out_data.
  always_ff @(posedge ti_clk) begin
    if (ti_rst_soft) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (mem_cnt != '0) state <= ST_LOAD;
        end
        ST_LOAD: begin
          state     <= ST_VALID;
          out_valid <= 1'b1;
          out_data  <= rd_word;
        end
        ST_VALID: begin
          if (pop) begin
            if (mem_cnt != '0) begin
              out_data <= rd_word;
            end else begin
              state     <= ST_EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_in_buffer.sv
// Directed bench for pipe_in_buffer at MEM_ADDR_WIDTH=4 (16 words): a vector
// table for single-cycle behaviour plus sequences for fill, stream, full and reset.
module tb_pipe_in_buffer;
  import pipe_in_buffer_pkg::*;

  localparam int AW = 4;

  logic         ti_clk;
  logic         ti_rst_soft;
  logic         ti_in_data_en;
  logic [15:0]  ti_in_data;
  logic [15:0]  ti_in_available;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [AW:0]  level;
  logic         overflow;
  out_state_t   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  pipe_in_buffer #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
    .ti_clk          (ti_clk),
    .ti_rst_soft     (ti_rst_soft),
    .ti_in_data_en   (ti_in_data_en),
    .ti_in_data      (ti_in_data),
    .ti_in_available (ti_in_available),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .level           (level),
    .overflow        (overflow),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic [15:0] din;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [4:0]  exp_level;
    logic [15:0] exp_avail;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge ti_clk);
    @(negedge ti_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ti_rst_soft   = 1'b1;
    ti_in_data_en = 1'b0;
    ti_in_data    = '0;
    out_ready     = 1'b0;
    tick();
    ti_rst_soft = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] d);
    ti_in_data_en = 1'b1;
    ti_in_data    = d;
    tick();
    ti_in_data_en = 1'b0;
  endtask

  // Pop every valid word for max_cycles cycles against the expected queue.
  task automatic drain(input string name, input int max_cycles);
    ti_in_data_en = 1'b0;
    out_ready     = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check({name, "_extra_word"}, {16'h0, out_data}, 32'hFFFF_FFFF);
        else check({name, "_data"}, {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
      tick();
    end
    check({name, "_words_left"}, exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    //           rst en rdy din       v  data      lvl avail  ovf
    vecs[0]  = '{1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'd16, 0};
    vecs[1]  = '{0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'd16, 0};
    vecs[2]  = '{0, 1, 1, 16'h1234, 0, 16'h0000, 1, 16'd16, 0};
    vecs[3]  = '{0, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'd15, 0};
    vecs[4]  = '{0, 0, 1, 16'h0000, 1, 16'h1234, 1, 16'd15, 0};
    vecs[5]  = '{0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'd15, 0};
    vecs[6]  = '{0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'd16, 0};
    vecs[7]  = '{0, 1, 0, 16'h00AA, 0, 16'h0000, 1, 16'd16, 0};
    vecs[8]  = '{0, 1, 0, 16'h00BB, 0, 16'h0000, 2, 16'd15, 0};
    vecs[9]  = '{0, 1, 0, 16'h00CC, 1, 16'h00AA, 3, 16'd14, 0};
    vecs[10] = '{0, 0, 0, 16'h0000, 1, 16'h00AA, 3, 16'd13, 0};
    vecs[11] = '{0, 0, 1, 16'h0000, 1, 16'h00BB, 2, 16'd13, 0};
    vecs[12] = '{0, 0, 1, 16'h0000, 1, 16'h00CC, 1, 16'd14, 0};
    vecs[13] = '{0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'd15, 0};
    vecs[14] = '{0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'd16, 0};
    vecs[15] = '{0, 1, 0, 16'h0011, 0, 16'h0000, 1, 16'd16, 0};
    vecs[16] = '{0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'd15, 0};
    vecs[17] = '{0, 0, 0, 16'h0000, 1, 16'h0011, 1, 16'd15, 0};
    vecs[18] = '{0, 1, 0, 16'h0022, 1, 16'h0011, 2, 16'd15, 0};
    vecs[19] = '{0, 0, 1, 16'h0000, 1, 16'h0022, 1, 16'd14, 0};
    vecs[20] = '{0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'd15, 0};
    vecs[21] = '{0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'd16, 0};

    ti_rst_soft   = 1'b1;
    ti_in_data_en = 1'b0;
    ti_in_data    = '0;
    out_ready     = 1'b0;
    @(negedge ti_clk);

    // table: outputs checked after the edge that consumes each vector
    for (int i = 0; i < NV; i++) begin
      ti_rst_soft   = vecs[i].rst;
      ti_in_data_en = vecs[i].en;
      out_ready     = vecs[i].rdy;
      ti_in_data    = vecs[i].din;
      tick();
      check($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("v%0d_data", i), {16'h0, out_data}, {16'h0, vecs[i].exp_data});
      check($sformatf("v%0d_level", i), {27'h0, level}, {27'h0, vecs[i].exp_level});
      check($sformatf("v%0d_avail", i), {16'h0, ti_in_available}, {16'h0, vecs[i].exp_avail});
      check($sformatf("v%0d_ovf", i), {31'h0, overflow}, {31'h0, vecs[i].exp_ovf});
    end

    // fill past capacity with the consumer stalled
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      write_word(16'(i));
      if (i < 16) exp_q.push_back(16'(i));
      if (i == 15) begin
        check("fill_level_at_16", {27'h0, level}, 32'd16);
        check("fill_ovf_before_drop", {31'h0, overflow}, 32'd0);
      end
      if (i == 16) check("fill_ovf_first_drop", {31'h0, overflow}, 32'd1);
    end
    check("fill_level", {27'h0, level}, 32'd16);
    check("fill_avail", {16'h0, ti_in_available}, 32'd0);
    check("fill_ovf", {31'h0, overflow}, 32'd1);
    drain("fill_drain", 40);
    check("fill_level_end", {27'h0, level}, 32'd0);
    check("fill_ovf_sticky", {31'h0, overflow}, 32'd1);

    // continuous stream with the consumer always ready
    begin
      int wr_i = 0;
      int rx_n = 0;
      int first_cyc = -1;
      int last_cyc = -1;
      do_reset();
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 100; cyc++) begin
        if (out_valid) begin
          if (exp_q.size() == 0) check("stream_extra_word", {16'h0, out_data}, 32'hFFFF_FFFF);
          else check("stream_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          rx_n++;
        end
        if (wr_i < 40) begin
          ti_in_data_en = 1'b1;
          ti_in_data    = 16'(wr_i);
          exp_q.push_back(16'(wr_i));
          wr_i++;
        end else begin
          ti_in_data_en = 1'b0;
        end
        tick();
      end
      check("stream_rx_count", rx_n, 40);
      check("stream_back_to_back", last_cyc - first_cyc, 39);
      check("stream_ovf", {31'h0, overflow}, 32'd0);
      check("stream_level_end", {27'h0, level}, 32'd0);
      out_ready = 1'b0;
    end

    // full buffer with push and pop on the same edge
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      write_word(16'h0100 + 16'(i));
      exp_q.push_back(16'h0100 + 16'(i));
    end
    check("full_level", {27'h0, level}, 32'd16);
    check("full_head", {16'h0, out_data}, 32'h0100);
    ti_in_data_en = 1'b1;
    ti_in_data    = 16'hDEAD;
    out_ready     = 1'b1;
    tick();
    ti_in_data_en = 1'b0;
    out_ready     = 1'b0;
    void'(exp_q.pop_front());
    check("full_pp_ovf", {31'h0, overflow}, 32'd1);
    check("full_pp_level", {27'h0, level}, 32'd15);
    check("full_pp_next", {16'h0, out_data}, 32'h0101);
    drain("full_drain", 30);

    // reset while holding seven words
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 7; i++) write_word(16'h0700 + 16'(i));
    check("mid_level_7", {27'h0, level}, 32'd7);
    ti_rst_soft   = 1'b1;
    ti_in_data_en = 1'b1;
    ti_in_data    = 16'h0BAD;
    tick();
    ti_rst_soft   = 1'b0;
    ti_in_data_en = 1'b0;
    check("mid_rst_level", {27'h0, level}, 32'd0);
    check("mid_rst_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_avail", {16'h0, ti_in_available}, 32'd16);
    check("mid_rst_ovf", {31'h0, overflow}, 32'd0);
    write_word(16'h7777);
    exp_q.push_back(16'h7777);
    drain("mid_drain", 10);
    check("mid_level_end", {27'h0, level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
